// File: rtl/grf_wb_ctrl.sv
// grf_wb_ctrl: write-side controller for the GRF write port.
// Merges the never-stalled W-stage result with a late secondary producer
// (valid/ready) buffered in a small FIFO, and reports pending writes so
// decode can stall readers of registers that are still in flight.
// Optional macro GRF_WB_TRACE_EN enables simulation trace displays on
// push, pop and kill events; without it no display code is compiled.
module grf_wb_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        m_we,
    input  logic [4:0]  m_a3,
    input  logic [31:0] m_wd,
    input  logic [31:0] m_pc,
    input  logic        s_valid,
    input  logic [4:0]  s_a3,
    input  logic [31:0] s_wd,
    input  logic [31:0] s_pc,
    output logic        s_ready,
    input  logic [4:0]  q_a1,
    input  logic [4:0]  q_a2,
    output logic        q_hit1,
    output logic        q_hit2,
    output logic        WE,
    output logic [4:0]  A3,
    output logic [31:0] WD,
    output logic [31:0] PC
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // FIFO storage; valid_r marks live (pushed, not popped, not killed) entries
    logic [4:0]       a3_r [DEPTH];
    logic [31:0]      wd_r [DEPTH];
    logic [31:0]      pc_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W:0]   count_r;

    logic main_req_s;
    logic push_s;
    logic pop_s;
    logic head_live_s;

    assign s_ready = (count_r != FULL_CNT);

    // Request decode: $0 targets are treated as no write at all
    always_comb begin
        main_req_s  = m_we && (m_a3 != 5'd0);
        push_s      = s_valid && s_ready && (s_a3 != 5'd0);
        pop_s       = !main_req_s && (count_r != {(PTR_W + 1){1'b0}});
        head_live_s = valid_r[rd_ptr_r];
    end

    // Pending-write query against live FIFO entries and the output stage
    always_comb begin
        q_hit1 = 1'b0;
        q_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_r[i] && (a3_r[i] == q_a1)) begin
                q_hit1 = 1'b1;
            end else begin
                q_hit1 = q_hit1;
            end
            if (valid_r[i] && (a3_r[i] == q_a2)) begin
                q_hit2 = 1'b1;
            end else begin
                q_hit2 = q_hit2;
            end
        end
        if (WE && (A3 == q_a1)) begin
            q_hit1 = 1'b1;
        end else begin
            q_hit1 = q_hit1;
        end
        if (WE && (A3 == q_a2)) begin
            q_hit2 = 1'b1;
        end else begin
            q_hit2 = q_hit2;
        end
        if (q_a1 == 5'd0) begin
            q_hit1 = 1'b0;
        end else begin
            q_hit1 = q_hit1;
        end
        if (q_a2 == 5'd0) begin
            q_hit2 = 1'b0;
        end else begin
            q_hit2 = q_hit2;
        end
    end

    // Output stage: main write wins, otherwise drain the FIFO head
    always_ff @(posedge Clk) begin
        if (Reset) begin
            WE <= 1'b0;
            A3 <= 5'd0;
            WD <= 32'd0;
            PC <= 32'd0;
        end else if (main_req_s) begin
            WE <= 1'b1;
            A3 <= m_a3;
            WD <= m_wd;
            PC <= m_pc;
        end else if (pop_s && head_live_s) begin
            WE <= 1'b1;
            A3 <= a3_r[rd_ptr_r];
            WD <= wd_r[rd_ptr_r];
            PC <= pc_r[rd_ptr_r];
        end else begin
            // killed head or nothing to write: idle slot, hold the bus
            WE <= 1'b0;
        end
    end

    // FIFO bookkeeping: kill by younger main write, pop, push, count
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_r  <= {DEPTH{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                a3_r[i] <= 5'd0;
                wd_r[i] <= 32'd0;
                pc_r[i] <= 32'd0;
            end
        end else begin
            if (main_req_s) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid_r[i] && (a3_r[i] == m_a3)) begin
                        valid_r[i] <= 1'b0;
`ifdef GRF_WB_TRACE_EN
                        $display("%d@%h: wb kill $%d <= %h", $time, pc_r[i], a3_r[i], wd_r[i]);
`else
                        // trace disabled
`endif
                    end
                end
            end
            if (pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + PTR_ONE;
`ifdef GRF_WB_TRACE_EN
                $display("%d@%h: wb pop $%d <= %h", $time, pc_r[rd_ptr_r], a3_r[rd_ptr_r], wd_r[rd_ptr_r]);
`else
                // trace disabled
`endif
            end
            if (push_s) begin
                a3_r[wr_ptr_r]    <= s_a3;
                wd_r[wr_ptr_r]    <= s_wd;
                pc_r[wr_ptr_r]    <= s_pc;
                valid_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r          <= wr_ptr_r + PTR_ONE;
`ifdef GRF_WB_TRACE_EN
                $display("%d@%h: wb push $%d <= %h", $time, s_pc, s_a3, s_wd);
`else
                // trace disabled
`endif
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_grf_wb_ctrl.sv
// Directed testbench for grf_wb_ctrl with hand-computed expectations.
module tb_grf_wb_ctrl;

    logic        Clk;
    logic        Reset;
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic [31:0] m_pc;
    logic        s_valid;
    logic [4:0]  s_a3;
    logic [31:0] s_wd;
    logic [31:0] s_pc;
    logic        s_ready;
    logic [4:0]  q_a1;
    logic [4:0]  q_a2;
    logic        q_hit1;
    logic        q_hit2;
    logic        WE;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic [31:0] PC;

    int checks;
    int errors;

    grf_wb_ctrl #(.DEPTH(4), .PTR_W(2)) dut (
        .Clk(Clk), .Reset(Reset),
        .m_we(m_we), .m_a3(m_a3), .m_wd(m_wd), .m_pc(m_pc),
        .s_valid(s_valid), .s_a3(s_a3), .s_wd(s_wd), .s_pc(s_pc),
        .s_ready(s_ready),
        .q_a1(q_a1), .q_a2(q_a2), .q_hit1(q_hit1), .q_hit2(q_hit2),
        .WE(WE), .A3(A3), .WD(WD), .PC(PC)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset = 1'b1;
        m_we = 1'b1; m_a3 = 5'd3; m_wd = 32'h33; m_pc = 32'h300;
        s_valid = 1'b1; s_a3 = 5'd5; s_wd = 32'h55; s_pc = 32'h500;
        q_a1 = 5'd5; q_a2 = 5'd0;

        // 1. reset with both producers active
        tick(); tick();
        check("rst_we", 32'(WE), 32'd0);
        check("rst_a3", 32'(A3), 32'd0);
        check("rst_wd", WD, 32'd0);
        check("rst_pc", PC, 32'd0);
        Reset = 1'b0;
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_qhit1", 32'(q_hit1), 32'd0);
        tick();
        check("rst_first_we", 32'(WE), 32'd1);
        check("rst_first_a3", 32'(A3), 32'd3);
        check("rst_first_wd", WD, 32'h33);
        m_we = 1'b0; s_valid = 1'b0;
        tick();
        check("rst_drain_we", 32'(WE), 32'd1);
        check("rst_drain_a3", 32'(A3), 32'd5);
        check("rst_drain_wd", WD, 32'h55);
        tick();
        check("rst_idle_we", 32'(WE), 32'd0);
        check("rst_idle_hold", 32'(A3), 32'd5);

        // 2. main path
        m_we = 1'b1; m_a3 = 5'd8; m_wd = 32'h1234; m_pc = 32'h3000;
        tick();
        check("main_we", 32'(WE), 32'd1);
        check("main_a3", 32'(A3), 32'd8);
        check("main_wd", WD, 32'h1234);
        check("main_pc", PC, 32'h3000);
        m_a3 = 5'd0; m_wd = 32'hDEAD;
        tick();
        check("main_a3zero_we", 32'(WE), 32'd0);
        check("main_a3zero_hold", WD, 32'h1234);

        // 3. fill and backpressure while main writes $9 every cycle
        m_we = 1'b1; m_a3 = 5'd9; m_wd = 32'h99; m_pc = 32'h900;
        for (int k = 1; k <= 4; k++) begin
            s_valid = 1'b1; s_a3 = 5'(k); s_wd = 32'(100 + k); s_pc = 32'(k);
            check("fill_ready", 32'(s_ready), 32'd1);
            tick();
            check("fill_main_a3", 32'(A3), 32'd9);
        end
        check("full_ready", 32'(s_ready), 32'd0);
        s_a3 = 5'd5; s_wd = 32'd105;
        tick();
        check("full_hold_ready", 32'(s_ready), 32'd0);
        m_we = 1'b0;
        tick();
        check("drain1_we", 32'(WE), 32'd1);
        check("drain1_a3", 32'(A3), 32'd1);
        check("drain1_wd", WD, 32'd101);
        check("after_pop_ready", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        check("drain2_a3", 32'(A3), 32'd2);
        for (int k = 3; k <= 5; k++) begin
            tick();
            check("drain_we", 32'(WE), 32'd1);
            check("drain_a3", 32'(A3), 32'(k));
            check("drain_wd", WD, 32'(100 + k));
        end
        tick();
        check("drain_done_we", 32'(WE), 32'd0);

        // 4. continuous pushes: wrap and simultaneous push/pop
        m_we = 1'b0;
        for (int k = 0; k < 10; k++) begin
            s_valid = 1'b1; s_a3 = 5'(10 + k); s_wd = 32'(k); s_pc = 32'(k);
            tick();
            if (k >= 1) begin
                check("wrap_we", 32'(WE), 32'd1);
                check("wrap_a3", 32'(A3), 32'(10 + k - 1));
            end
            check("wrap_ready", 32'(s_ready), 32'd1);
        end
        s_valid = 1'b0;
        tick();
        check("wrap_last_a3", 32'(A3), 32'd19);
        check("wrap_last_wd", WD, 32'd9);
        tick();
        check("wrap_empty_we", 32'(WE), 32'd0);

        // 5. kill: younger main write to $7 invalidates queued $7
        m_we = 1'b1; m_a3 = 5'd9; m_wd = 32'h9; m_pc = 32'h90;
        s_valid = 1'b1; s_a3 = 5'd7; s_wd = 32'hAAAA; s_pc = 32'h70;
        tick();
        check("kill_main9", 32'(A3), 32'd9);
        s_valid = 1'b0;
        m_a3 = 5'd7; m_wd = 32'hBBBB; m_pc = 32'h71;
        q_a1 = 5'd7;
        #1;
        check("kill_qhit_fifo", 32'(q_hit1), 32'd1);
        tick();
        check("kill_we", 32'(WE), 32'd1);
        check("kill_a3", 32'(A3), 32'd7);
        check("kill_wd", WD, 32'hBBBB);
        check("kill_qhit_out", 32'(q_hit1), 32'd1);
        m_we = 1'b0;
        tick();
        check("kill_pop_we", 32'(WE), 32'd0);
        check("kill_pop_wd", WD, 32'hBBBB);
        check("kill_qhit_gone", 32'(q_hit1), 32'd0);
        tick();
        check("kill_after_we", 32'(WE), 32'd0);

        // 6. query
        s_valid = 1'b1; s_a3 = 5'd12; s_wd = 32'hCC; s_pc = 32'hC0;
        q_a1 = 5'd12; q_a2 = 5'd0;
        tick();
        s_valid = 1'b0;
        #1;
        check("q_push_we", 32'(WE), 32'd0);
        check("q_hit1_fifo", 32'(q_hit1), 32'd1);
        check("q_hit2_zero", 32'(q_hit2), 32'd0);
        q_a2 = 5'd13;
        #1;
        check("q_hit2_miss", 32'(q_hit2), 32'd0);
        tick();
        check("q_drain_a3", 32'(A3), 32'd12);
        check("q_hit1_out", 32'(q_hit1), 32'd1);
        tick();
        check("q_hit1_clear", 32'(q_hit1), 32'd0);

        // reset in the middle of a drain discards queued entries
        m_we = 1'b1; m_a3 = 5'd9;
        s_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s_a3 = 5'(20 + k); s_wd = 32'(k);
            tick();
        end
        s_valid = 1'b0; m_we = 1'b0;
        tick();
        check("mid_drain_a3", 32'(A3), 32'd20);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        q_a1 = 5'd21;
        #1;
        check("mid_rst_we", 32'(WE), 32'd0);
        check("mid_rst_qhit", 32'(q_hit1), 32'd0);
        tick();
        check("mid_rst_nodrain", 32'(WE), 32'd0);
        check("mid_rst_ready", 32'(s_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grf_wb_ctrl.md
Name: grf_wb_ctrl

Overview:
Write-side controller for the GRF write port. It merges two result producers into the single GRF write port (WE/A3/WD/PC):
- the in-order W-stage result, which is never stalled;
- a late secondary producer (MDU/long-latency result) using a valid/ready handshake.

Secondary results are buffered in a small FIFO and drained into free write-port slots. It also reports pending writes so decode can stall readers.

Parameters:
DEPTH, 4, secondary FIFO entries; power of two, minimum 2
PTR_W, 2, pointer width = log2(DEPTH)

Ports:
Clk  in  1  clock
Reset  in  1  synchronous, active-high reset
m_we  in  1  W-stage write request
m_a3  in  5  W-stage destination register
m_wd  in  32  W-stage write data
m_pc  in  32  W-stage instruction PC
s_valid  in  1  secondary result valid
s_a3  in  5  secondary destination register
s_wd  in  32  secondary write data
s_pc  in  32  secondary instruction PC
s_ready  out  1  FIFO can accept a secondary result
q_a1  in  5  decode query address 1
q_a2  in  5  decode query address 2
q_hit1  out  1  write to q_a1 still pending
q_hit2  out  1  write to q_a2 still pending
WE  out  1  GRF write enable (registered)
A3  out  5  GRF write address (registered)
WD  out  32  GRF write data (registered)
PC  out  32  GRF write PC (registered)

Behaviour:
- Reset (synchronous, posedge Clk with Reset=1):
  - WE=0, A3=0, WD=0, PC=0.
  - FIFO empty: count=0, rd/wr pointers=0, all entries invalid.
  - s_ready=1 from the next cycle.
  - Any queued secondary results are discarded, including in the middle of a drain.
- Write requests: a main request is m_we=1 with m_a3!=0. m_we with m_a3=0 counts as idle (no GRF write).
- Output stage, updated every posedge. Priority:
  - Main request: WE=1, {A3,WD,PC} <= {m_a3,m_wd,m_pc}.
  - Else, FIFO non-empty: head entry is popped and presented, WE=1.
  - Else: WE=0; A3/WD/PC hold their previous values.
  - Latency is exactly 1 cycle from input to WE.
- Push:
  - A push occurs when s_valid && s_ready at a posedge. s_valid with s_a3=0 is accepted and dropped (no push).
  - s_ready = (count != DEPTH), combinational from registered count only.
  - When full, s_ready=0 even if a pop happens in the same cycle.
- FIFO mechanics:
  - Push and pop in the same cycle: count unchanged.
  - Pointers wrap modulo DEPTH.
  - An entry pushed in cycle N can be popped at the earliest in cycle N+1 (no same-cycle bypass from s_* to the output).
- Kill rule: a main request whose m_a3 equals the a3 of a valid, non-popped FIFO entry invalidates that entry, because the main write is younger.
  - A killed entry still occupies its slot.
  - When it reaches the head it is popped without asserting WE. That cycle is otherwise an idle slot.
- Pending query:
  - q_hitN = (q_aN != 0) && (a valid FIFO entry has a3 == q_aN, or (WE && A3 == q_aN)).
  - Combinational. $0 never hits.
- Decode contract: decode stalls on q_hit for both sources and destinations. This guarantees program order; the kill rule is a defensive backstop.
- No error output. Overflow cannot occur because of the handshake.

Optional Feature:
Macro: GRF_WB_TRACE_EN.
- Defined: simulation-only display on every push, every pop and every kill, formatted as "%d@%h: wb push|pop|kill $%d <= %h" using $time, pc, a3, wd.
- Not defined: no display statements compiled. Functionality is identical.

Test Plan:
1. Reset: Reset=1 for 2 cycles with s_valid=1 (s_a3=5) and m_we=1 (m_a3=3) held throughout -> WE=0, A3=0, WD=0, PC=0, s_ready=1 after release, q_hit1=0 for q_a1=5; the first cycle after release then writes $3.
2. Main path: m_we=1, m_a3=8, m_wd=32'h1234, m_pc=32'h3000 at cycle N -> WE=1, A3=8, WD=32'h1234, PC=32'h3000 at N+1; m_a3=0 -> WE=0 next cycle.
3. Fill/backpressure: 4 secondary pushes (a3=1..4) while m_we=1 (m_a3=9) every cycle -> s_ready=0 after the 4th; fifth s_valid is held without push; m_we dropped -> drain $1,$2,$3,$4 in order, one per cycle; s_ready=1 one cycle after the first pop.
4. Wrap and simultaneous push/pop: 10 continuous secondary pushes with m_we=0 -> WE every cycle from the 2nd, addresses in order, count never exceeds 1, pointers wrap correctly.
5. Kill: push s_a3=7 (wd=32'hAAAA) while a main write targets $9; next cycle main m_a3=7, wd=32'hBBBB -> GRF sees only $7 <= 32'hBBBB; the killed slot pops with WE=0; q_hit1(q_a1=7) goes 0 after the main write leaves the output stage.
6. Query: FIFO holds a3=12; q_a1=12, q_a2=0 -> q_hit1=1, q_hit2=0; after the drain cycle q_hit1 stays 1 while WE && A3=12 is held, and is 0 in the cycle after.
